// File: rtl/modexp_sequencer.sv
// Montgomery-domain left-to-right square-and-multiply sequencer for x^e mod m.
// Drives an external Montgomery multiplier through a start/done handshake.
module modexp_sequencer #(
  parameter int unsigned WIDTH = 512
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] rmodm,
  input  logic [WIDTH-1:0] rsqmodm,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_m,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_result
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSqr,
    StMul,
    StPost,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic              wait_q, wait_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  mod_q, mod_d;
  logic [WIDTH-1:0]  rsq_q, rsq_d;
  logic [WIDTH-1:0]  exp_q, exp_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  xm_q, xm_d;
  logic [WIDTH-1:0]  result_q, result_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      wait_q   <= 1'b0;
      idx_q    <= IdxTop;
      mod_q    <= '0;
      rsq_q    <= '0;
      exp_q    <= '0;
      x_q      <= '0;
      a_q      <= '0;
      xm_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      mod_q    <= mod_d;
      rsq_q    <= rsq_d;
      exp_q    <= exp_d;
      x_q      <= x_d;
      a_q      <= a_d;
      xm_q     <= xm_d;
      result_q <= result_d;
    end
  end

  // Operands come straight from registers that only change on mul_done,
  // so they stay stable for the whole multiplication.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    mul_m = mod_q;
    unique case (state_q)
      StPre: begin
        mul_a = x_q;
        mul_b = rsq_q;
      end
      StSqr: begin
        mul_a = a_q;
        mul_b = a_q;
      end
      StMul: begin
        mul_a = a_q;
        mul_b = xm_q;
      end
      StPost: begin
        mul_a = a_q;
        mul_b = One;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    mod_d     = mod_q;
    rsq_d     = rsq_q;
    exp_d     = exp_q;
    x_d       = x_q;
    a_d       = a_q;
    xm_d      = xm_q;
    result_d  = result_q;
    mul_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mod_d   = modulus;
          rsq_d   = rsqmodm;
          exp_d   = exponent;
          x_d     = x;
          a_d     = rmodm;
          idx_d   = IdxTop;
          wait_d  = 1'b0;
          state_d = StPre;
        end
      end
      StPre, StSqr, StMul, StPost: begin
        if (!wait_q) begin
          mul_start = 1'b1;
          wait_d    = 1'b1;
        end else if (mul_done) begin
          wait_d = 1'b0;
          if (state_q == StPre) begin
            xm_d    = mul_result;
            state_d = StSqr;
          end else if (state_q == StPost) begin
            a_d      = mul_result;
            result_d = mul_result;
            state_d  = StFin;
          end else begin
            a_d = mul_result;
            if (state_q == StSqr && exp_q[idx_q]) begin
              state_d = StMul;
            end else if (idx_q == '0) begin
              state_d = StPost;
            end else begin
              idx_d   = idx_q - IdxW'(1);
              state_d = StSqr;
            end
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        wait_d  = 1'b0;
      end
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StFin);
  assign result = result_q;

endmodule
